// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared types and constants for the multiply/divide unit.
//   - MULDIV_XLEN : default operand/result width
//   - muldiv_op_t : operation encoding (RV32M ordering)
//   - state_t     : sequencer states
//   - op_* helpers: operand signedness / op class decode
package muldiv_pkg;

  localparam int MULDIV_XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Divide-class ops occupy the upper half of the encoding.
  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // Operand a is treated as two's complement.
  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  // Operand b is treated as two's complement.
  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit. One shift-add (multiply) or restoring
//   (divide) step per CALC cycle on operand magnitudes, then a single FIX
//   cycle applies sign correction and divide special cases and registers
//   the result. Latency is fixed: the accepting edge plus 32 CALC edges
//   plus the FIX edge, so done rises after the 34th enabled edge.
//
// Ports
//   clk     : clock, all state on rising edge
//   reset   : asynchronous active-low reset
//   run     : global enable, 0 freezes all state
//   flush   : synchronous abort to IDLE (qualified by run)
//   start   : request an operation (accepted in IDLE only)
//   op      : muldiv_op_t operation
//   a, b    : operands
//   rd      : destination register address
//   busy    : high in every state except IDLE
//   done    : high in DONE only
//   waddr   : latched rd
//   wdata   : result
//   reg_we  : done and waddr != 0
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            flush,
  input  logic            start,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
  output logic            reg_we
);

  localparam int               CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};

  // Conditional two's-complement negation, result width.
  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  // Conditional two's-complement negation, full product width.
  function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  // Control state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_waddr;
  logic [XLEN-1:0]  r_wdata;

  // Captured operation (data, no reset)
  muldiv_op_t       r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_mcand;   // |a| for multiply, |b| for divide
  logic [2*XLEN-1:0] r_acc;    // {hi, lo}: product, or {remainder, quotient}
  logic             r_neg;     // final result needs negation

  // Capture-side decode
  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic             w_is_div_in;

  // Iteration datapath
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;

  // FIX-stage result
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_result;

  assign w_accept = (r_state == S_IDLE) && start && !flush;

  // Capture: operand magnitudes and result sign
  always_comb begin
    w_is_div_in = op_is_div(op);
    w_a_neg     = op_a_signed(op) && a[XLEN-1];
    w_b_neg     = op_b_signed(op) && b[XLEN-1];
    w_a_mag     = neg_w(a, w_a_neg);
    w_b_mag     = neg_w(b, w_b_neg);
  end

  // One multiply step: conditionally add multiplicand into the high half,
  // then shift the whole accumulator right, consuming one multiplier bit.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
  end

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder; keep the difference when it does not go negative.
  always_comb begin
    w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_mcand};
    w_qbit      = ~w_div_diff[XLEN];
    w_div_nxt   = {(w_qbit ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                   r_acc[XLEN-2:0], w_qbit};
    w_acc_nxt   = op_is_div(r_op) ? w_div_nxt : w_mul_nxt;
  end

  // Sign correction and divide special cases
  always_comb begin
    w_prod     = neg_p(r_acc, r_neg);
    w_quot     = r_acc[XLEN-1:0];
    w_rem      = r_acc[2*XLEN-1:XLEN];
    w_div_zero = (r_b == '0);
    w_div_ovf  = (r_a == MOST_NEG) && (r_b == ALL_ONES);
    w_result   = '0;
    unique case (r_op)
      MUL:                  w_result = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU:  w_result = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU: begin
        if (w_div_zero)                   w_result = ALL_ONES;
        else if (r_op == DIV && w_div_ovf) w_result = r_a;
        else                              w_result = neg_w(w_quot, r_neg);
      end
      REM, REMU: begin
        if (w_div_zero)                   w_result = r_a;
        else if (r_op == REM && w_div_ovf) w_result = '0;
        else                              w_result = neg_w(w_rem, r_neg);
      end
      default:              w_result = '0;
    endcase
  end

  // Next-state logic; flush wins over everything including start
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start)              w_state_nxt = S_CALC;
      S_CALC: if (r_cnt == CNT_LAST)  w_state_nxt = S_FIX;
      S_FIX:                          w_state_nxt = S_DONE;
      S_DONE:                         w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (run) begin
      r_state <= w_state_nxt;
      if (flush || w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_waddr <= rd;
      end
      if (r_state == S_FIX && !flush) begin
        r_wdata <= w_result;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (run) begin
      if (w_accept) begin
        r_op    <= op;
        r_a     <= a;
        r_b     <= b;
        r_mcand <= w_is_div_in ? w_b_mag : w_a_mag;
        r_acc   <= {{XLEN{1'b0}}, (w_is_div_in ? w_a_mag : w_b_mag)};
        if (!w_is_div_in)    r_neg <= w_a_neg ^ w_b_neg;
        else if (op[1])      r_neg <= w_a_neg;            // REM/REMU
        else                 r_neg <= w_a_neg ^ w_b_neg;  // DIV/DIVU
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_nxt;
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign waddr  = r_waddr;
  assign wdata  = r_wdata;
  assign reg_we = done && (r_waddr != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        run;
  logic        flush;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_we;

  int checks = 0;
  int errors = 0;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .flush  (flush),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd     (rd),
    .busy   (busy),
    .done   (done),
    .waddr  (waddr),
    .wdata  (wdata),
    .reg_we (reg_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input muldiv_op_t o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] r);
    op = o; a = av; b = bv; rd = r; start = 1'b1;
    tick();            // edge 1: accepted
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.op, v.a, v.b, v.rd);
    chk($sformatf("%s busy", v.op.name()), 32'(busy), 32'd1);
    repeat (32) tick(); // edges 2..33
    chk($sformatf("%s done_early", v.op.name()), 32'(done), 32'd0);
    tick();             // edge 34
    chk($sformatf("%s done", v.op.name()), 32'(done), 32'd1);
    chk($sformatf("%s wdata a=%h b=%h", v.op.name(), v.a, v.b), wdata, v.exp);
    chk($sformatf("%s waddr", v.op.name()), 32'(waddr), 32'(v.rd));
    chk($sformatf("%s reg_we", v.op.name()), 32'(reg_we), 32'(v.rd != 5'd0));
    tick();             // edge 35: back to IDLE
    chk($sformatf("%s done_after", v.op.name()), 32'(done), 32'd0);
    chk($sformatf("%s idle", v.op.name()), 32'(busy), 32'd0);
    chk($sformatf("%s wdata_hold", v.op.name()), wdata, v.exp);
  endtask

  initial begin
    int seen;

    vecs[0]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
    vecs[1]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE};
    vecs[2]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF};
    vecs[4]  = '{MUL,    32'h12345678, 32'h00000010, 5'd4,  32'h23456780};
    vecs[5]  = '{MULHU,  32'h80000000, 32'h00000004, 5'd6,  32'h00000002};
    vecs[6]  = '{DIV,    32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFD};
    vecs[7]  = '{REM,    32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFF};
    vecs[8]  = '{DIV,    32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000};
    vecs[9]  = '{REM,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000};
    vecs[10] = '{DIVU,   32'd100,      32'd0,        5'd11, 32'hFFFFFFFF};
    vecs[11] = '{REMU,   32'd100,      32'd0,        5'd12, 32'd100};
    vecs[12] = '{DIVU,   32'd100,      32'd0,        5'd0,  32'hFFFFFFFF};
    vecs[13] = '{DIVU,   32'd100,      32'd7,        5'd13, 32'd14};
    vecs[14] = '{REMU,   32'd100,      32'd7,        5'd14, 32'd2};
    vecs[15] = '{DIV,    32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD};
    vecs[16] = '{REM,    32'd7,        32'hFFFFFFFE, 5'd16, 32'd1};
    vecs[17] = '{REM,    32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFF9};

    reset = 1'b0; run = 1'b1; flush = 1'b0; start = 1'b0;
    op = MUL; a = '0; b = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy",   32'(busy),   32'd0);
    chk("rst done",   32'(done),   32'd0);
    chk("rst reg_we", 32'(reg_we), 32'd0);
    chk("rst wdata",  wdata,       32'd0);
    chk("rst waddr",  32'(waddr),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Start pulsed mid-CALC with different operands is ignored;
    // start during DONE is not accepted either.
    issue(MUL, 32'h7, 32'hFFFFFFFD, 5'd5);
    repeat (4) tick();                         // edge 5
    op = DIVU; a = 32'd100; b = 32'd7; rd = 5'd9; start = 1'b1;
    tick();                                    // edge 6
    start = 1'b0;
    repeat (27) tick();                        // edge 33
    chk("ign done_early", 32'(done), 32'd0);
    tick();                                    // edge 34
    chk("ign done",  32'(done),  32'd1);
    chk("ign wdata", wdata,      32'hFFFFFFEB);
    chk("ign waddr", 32'(waddr), 32'd5);
    start = 1'b1;
    tick();                                    // edge 35: DONE -> IDLE
    start = 1'b0;
    chk("done_start busy", 32'(busy), 32'd0);
    tick();

    // run=0 for 5 cycles mid-CALC stretches latency to edge 39;
    // run=0 in DONE holds done/reg_we/wdata.
    issue(DIVU, 32'd100, 32'd7, 5'd3);
    repeat (9) tick();                         // edge 10
    run = 1'b0;
    repeat (5) tick();                         // edges 11..15 frozen
    chk("frz busy", 32'(busy), 32'd1);
    run = 1'b1;
    repeat (23) tick();                        // edge 38
    chk("frz done_early", 32'(done), 32'd0);
    tick();                                    // edge 39
    chk("frz done",  32'(done), 32'd1);
    chk("frz wdata", wdata,     32'd14);
    run = 1'b0;
    repeat (3) tick();
    chk("frz hold done",   32'(done),   32'd1);
    chk("frz hold reg_we", 32'(reg_we), 32'd1);
    chk("frz hold wdata",  wdata,       32'd14);
    run = 1'b1;
    tick();
    chk("frz exit", 32'(done), 32'd0);

    // flush overrides start in IDLE
    op = MUL; a = 32'd3; b = 32'd3; rd = 5'd4; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start busy", 32'(busy), 32'd0);

    // flush in FIX: back to IDLE, no done, wdata keeps last result
    issue(REMU, 32'd100, 32'd7, 5'd6);
    repeat (32) tick();                        // edge 33, in FIX
    flush = 1'b1;
    tick();                                    // edge 34
    flush = 1'b0;
    chk("fix_flush busy",  32'(busy), 32'd0);
    chk("fix_flush done",  32'(done), 32'd0);
    chk("fix_flush wdata", wdata,     32'd14);
    seen = 0;
    repeat (5) begin
      tick();
      if (done || reg_we) seen = 1;
    end
    chk("fix_flush no_done", 32'(seen), 32'd0);

    // reset mid-CALC: outputs clear immediately, nothing is written later
    issue(MUL, 32'h7, 32'h6, 5'd7);
    repeat (9) tick();                         // edge 10
    #2;
    reset = 1'b0;
    #1;
    chk("midrst busy",  32'(busy),  32'd0);
    chk("midrst done",  32'(done),  32'd0);
    chk("midrst wdata", wdata,      32'd0);
    chk("midrst waddr", 32'(waddr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (done || reg_we || busy) seen = 1;
    end
    chk("midrst no_write", 32'(seen), 32'd0);

    // fresh operation after reset
    run_vec(vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  input  1  global enable; 0 freezes all state.
REQ-005 SHALL have port flush  input  1  synchronous abort to IDLE (only when run=1).
REQ-006 SHALL have port start  input  1  request a new operation.
REQ-007 SHALL have port op  input  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have port a  input  XLEN  operand 1, from register-file read port A.
REQ-009 SHALL have port b  input  XLEN  operand 2, from register-file read port B.
REQ-010 SHALL have port rd  input  5  destination register address.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  high only in DONE.
REQ-013 SHALL have port waddr  output  5  latched rd, to register-file write address.
REQ-014 SHALL have port wdata  output  XLEN  result, to register-file write data.
REQ-015 SHALL have port reg_we  output  1  write enable, = done AND (waddr != 0).

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIX, DONE; every transition requires run=1 at the edge.
REQ-017 SHALL accept start only in IDLE; capture op, a, b, rd and enter CALC with cycle counter = 0.
REQ-018 SHALL ignore start in CALC, FIX, DONE; captured operands remain unchanged.
REQ-019 SHALL do one iteration per CALC edge (shift-add multiply, restoring divide on magnitudes), 32 iterations total, counter 0..31, then enter FIX.
REQ-020 SHALL, in FIX, apply sign correction and the special cases, register wdata, then enter DONE.
REQ-021 SHALL leave DONE for IDLE after exactly one run=1 edge; a start at that edge is not accepted.
REQ-022 SHALL give fixed latency: done/reg_we high after exactly 34 run=1 edges following acceptance.
REQ-023 SHALL select MUL low XLEN bits, MULH/MULHSU/MULHU high XLEN bits of the 2*XLEN product with signed x signed, signed x unsigned, and unsigned x unsigned operands respectively.
REQ-024 SHALL truncate DIV/REM quotients toward zero; the remainder takes the dividend's sign.
REQ-025 SHALL, on divide by zero, return all-ones quotient for DIV/DIVU and dividend a for REM/REMU.
REQ-026 SHALL, on DIV/REM overflow (a = most negative, b = -1), return quotient = a and remainder = 0.
REQ-027 SHALL, with run=0, hold state, counter, and all outputs; done/reg_we held high in DONE.
REQ-028 SHALL, on flush with run=1, go to IDLE next edge from any state; flush overrides start.
REQ-029 SHALL hold wdata and waddr stable from FIX exit until the next accepted start.

Reset
REQ-030 SHALL, on reset low, immediately set state=IDLE, counter=0, busy=0, done=0, reg_we=0, wdata=0, waddr=0.
REQ-031 SHALL abort any in-flight operation on reset mid-operation with no write; operation restarts only on a new start after reset release.

Structure
REQ-032 SHALL take muldiv_op_t and the XLEN default constant from shared package muldiv_pkg.
REQ-033 SHALL keep the datapath in a single module with no sub-module; the counter and FSM are local.

Verification
REQ-034 MUL a=7, b=0xFFFFFFFD, rd=5 -> at edge 34 wdata=0xFFFFFFEB, waddr=5, reg_we=1 for one cycle.
REQ-035 MULHU a=b=0xFFFFFFFF -> wdata=0xFFFFFFFE; MULH same operands -> wdata=0x00000000.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-037 DIVU a=100, b=0 -> 0xFFFFFFFF; REMU a=100, b=0 -> 100; rd=0 -> done=1, reg_we=0.
REQ-038 Start pulsed in CALC with other operands -> ignored, first result unchanged; run=0 for 5 cycles mid-CALC -> done at edge 39.
REQ-039 Reset asserted at CALC edge 10 -> outputs zero immediately, no reg_we; flush in FIX -> IDLE, no done.
